slc3_datapath_w: RTL

Parametrised SLC-3 datapath: WIDTH-bit internal bus, eight-entry register file, PC/IR/MAR/MDR/CC/BEN/LED registers, address adder, and an ALU extended with SUB, XOR and an iterative shift-add multiplier. It sits between the SLC-3 control FSM, which drives every load, gate and mux select, and the memory/IO interface, which supplies MDR_In. At WIDTH=16 it executes the standard LC-3 datapath; the multiplier uses a start/busy/done handshake so the control FSM can wait on it.

---
 rtl/slc3_datapath_w.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/slc3_datapath_w.sv
// rtl/slc3_datapath_w.sv - SLC-3 datapath with extended ALU and iterative shift-add multiplier
module slc3_datapath_w #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LD_MAR,
  input  logic             LD_MDR,
  input  logic             LD_IR,
  input  logic             LD_BEN,
  input  logic             LD_CC,
  input  logic             LD_REG,
  input  logic             LD_PC,
  input  logic             LD_LED,
  input  logic             GatePC,
  input  logic             GateMDR,
  input  logic             GateALU,
  input  logic             GateMARMUX,
  input  logic             SR2MUX,
  input  logic             ADDR1MUX,
  input  logic             MARMUX,
  input  logic             MIO_EN,
  input  logic             DRMUX,
  input  logic             SR1MUX,
  input  logic [1:0]       PCMUX,
  input  logic [1:0]       ADDR2MUX,
  input  logic [2:0]       ALUK,
  input  logic             MUL_Start,
  input  logic [WIDTH-1:0] MDR_In,
  output logic [WIDTH-1:0] MAR,
  output logic [WIDTH-1:0] MDR,
  output logic [WIDTH-1:0] IR,
  output logic [WIDTH-1:0] PC,
  output logic             BEN,
  output logic [9:0]       LED,
  output logic             MUL_Busy,
  output logic             MUL_Done,
  output logic             Bus_Conflict
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    MUL_IDLE,
    MUL_RUN,
    MUL_DONE
  } mul_state_e;

  logic [WIDTH-1:0] pc_q, ir_q, mar_q, mdr_q, prod_q;
  logic [WIDTH-1:0] rf_q [8];
  logic [9:0]       led_q;
  logic             n_q, z_q, p_q, ben_q;

  mul_state_e       mul_state_q, mul_state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d, prod_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] bus, sr1_out, sr2_out, alu_b, alu_out;
  logic [WIDTH-1:0] addr1, addr2, adder, marmux_out, pc_d, mdr_d;
  logic [WIDTH-1:0] sext5, sext6, sext9, sext11;
  logic [2:0]       sr1_idx, dr_idx, gate_cnt;
  logic             ben_d;

  assign sext5  = {{(WIDTH-5){ir_q[4]}},   ir_q[4:0]};
  assign sext6  = {{(WIDTH-6){ir_q[5]}},   ir_q[5:0]};
  assign sext9  = {{(WIDTH-9){ir_q[8]}},   ir_q[8:0]};
  assign sext11 = {{(WIDTH-11){ir_q[10]}}, ir_q[10:0]};

  assign sr1_idx = SR1MUX ? ir_q[8:6] : ir_q[11:9];
  assign dr_idx  = DRMUX ? 3'd7 : ir_q[11:9];
  assign sr1_out = rf_q[sr1_idx];
  assign sr2_out = rf_q[ir_q[2:0]];
  assign alu_b   = SR2MUX ? sext5 : sr2_out;

  assign addr1 = ADDR1MUX ? sr1_out : pc_q;
  always_comb begin
    addr2 = '0;
    case (ADDR2MUX)
      2'b00: addr2 = '0;
      2'b01: addr2 = sext6;
      2'b10: addr2 = sext9;
      2'b11: addr2 = sext11;
      default: addr2 = '0;
    endcase
  end
  assign adder      = addr1 + addr2;
  assign marmux_out = MARMUX ? {{(WIDTH-8){1'b0}}, ir_q[7:0]} : adder;

  always_comb begin
    alu_out = '0;
    case (ALUK)
      3'b000: alu_out = sr1_out + alu_b;
      3'b001: alu_out = sr1_out & alu_b;
      3'b010: alu_out = ~sr1_out;
      3'b011: alu_out = sr1_out;
      3'b100: alu_out = prod_q;
      3'b101: alu_out = sr1_out - alu_b;
      3'b110: alu_out = sr1_out ^ alu_b;
      3'b111: alu_out = alu_b;
      default: alu_out = '0;
    endcase
  end

  // A gate collision forces the bus to zero rather than OR-ing drivers together.
  assign gate_cnt     = 3'(GatePC) + 3'(GateMDR) + 3'(GateALU) + 3'(GateMARMUX);
  assign Bus_Conflict = (gate_cnt > 3'd1);

  always_comb begin
    bus = '0;
    if (!Bus_Conflict) begin
      if (GatePC)          bus = pc_q;
      else if (GateMDR)    bus = mdr_q;
      else if (GateALU)    bus = alu_out;
      else if (GateMARMUX) bus = marmux_out;
    end
  end

  always_comb begin
    pc_d = pc_q;
    case (PCMUX)
      2'b00: pc_d = pc_q + 1'b1;
      2'b01: pc_d = bus;
      2'b10: pc_d = adder;
      2'b11: pc_d = pc_q;
      default: pc_d = pc_q;
    endcase
  end

  assign mdr_d = MIO_EN ? MDR_In : bus;
  assign ben_d = (ir_q[11] & n_q) | (ir_q[10] & z_q) | (ir_q[9] & p_q);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      led_q <= '0;
      ben_q <= 1'b0;
      n_q   <= 1'b0;
      z_q   <= 1'b0;
      p_q   <= 1'b0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      if (LD_PC)  pc_q  <= pc_d;
      if (LD_IR)  ir_q  <= bus;
      if (LD_MAR) mar_q <= bus;
      if (LD_MDR) mdr_q <= mdr_d;
      if (LD_LED) led_q <= ir_q[9:0];
      if (LD_BEN) ben_q <= ben_d;
      if (LD_REG) rf_q[dr_idx] <= bus;
      if (LD_CC) begin
        n_q <= bus[WIDTH-1];
        z_q <= (bus == '0);
        p_q <= !bus[WIDTH-1] && (bus != '0);
      end
    end
  end

  // Counter starts at WIDTH and the last RUN cycle is the one that sees 1.
  always_comb begin
    mul_state_d = mul_state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    prod_d      = prod_q;
    case (mul_state_q)
      MUL_IDLE: begin
        if (MUL_Start) begin
          mcand_d     = sr1_out;
          mplier_d    = alu_b;
          acc_d       = '0;
          cnt_d       = CW'(WIDTH);
          mul_state_d = MUL_RUN;
        end
      end
      MUL_RUN: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) mul_state_d = MUL_DONE;
      end
      MUL_DONE: begin
        prod_d      = acc_q;
        mul_state_d = MUL_IDLE;
      end
      default: mul_state_d = MUL_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      mul_state_q <= MUL_IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      prod_q      <= '0;
    end else begin
      mul_state_q <= mul_state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      prod_q      <= prod_d;
    end
  end

  assign MUL_Busy = (mul_state_q != MUL_IDLE);
  assign MUL_Done = (mul_state_q == MUL_DONE);

  assign MAR = mar_q;
  assign MDR = mdr_q;
  assign IR  = ir_q;
  assign PC  = pc_q;
  assign BEN = ben_q;
  assign LED = led_q;

endmodule
